// File: rtl/elastic_fork.sv
// One-token eager fork: holds a token and offers it to every consumer selected by output_mask.
// Consumers complete independently, and a new token may load in the cycle the last one drains.
module elastic_fork #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_OUTPUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  valid_input,
    output logic                  stop_input,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic [NUM_OUTPUT-1:0] valid_output,
    input  logic [NUM_OUTPUT-1:0] stop_output,
    input  logic [NUM_OUTPUT-1:0] output_mask,
    output logic [15:0]           token_count
);

    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StFull  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_OUTPUT-1:0] pending_q, pending_d;
    logic [15:0]           count_q, count_d;
    logic                  full, done, in_xfer, mask_zero;
    logic [1:0]            count_inc;

    always_comb begin
        full         = (state_q == StFull);
        // Done when no still-pending consumer is stalled this cycle.
        done         = full && ((pending_q & stop_output) == '0);
        stop_input   = full && !done;
        in_xfer      = valid_input && !stop_input;
        mask_zero    = (output_mask == '0);
        valid_output = full ? pending_q : '0;
        output_data  = data_q;
        token_count  = count_q;
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        // A pending port survives only if it was stalled.
        pending_d = full ? (pending_q & stop_output) : '0;
        // A draining token and a discarded (empty-mask) token can retire in the same cycle.
        count_inc = {1'b0, done} + {1'b0, in_xfer && mask_zero};
        count_d   = count_q + 16'(count_inc);
        if (done) begin
            state_d = StEmpty;
        end
        if (in_xfer && !mask_zero) begin
            state_d   = StFull;
            data_d    = input_data;
            pending_d = output_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StEmpty;
            data_q    <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_elastic_fork.sv
// Bench for elastic_fork: directed scenarios plus randomized traffic, checked against a
// token-level model that tracks the held token and the list of consumers still owed it.
module tb_elastic_fork;

    localparam int DW = 32;
    localparam int NO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] input_data;
    logic          valid_input;
    logic          stop_input;
    logic [DW-1:0] output_data;
    logic [NO-1:0] valid_output;
    logic [NO-1:0] stop_output;
    logic [NO-1:0] output_mask;
    logic [15:0]   token_count;

    always #5 clk = ~clk;

    elastic_fork #(
        .DATA_WIDTH(DW),
        .NUM_OUTPUT(NO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .valid_input (valid_input),
        .stop_input  (stop_input),
        .output_data (output_data),
        .valid_output(valid_output),
        .stop_output (stop_output),
        .output_mask (output_mask),
        .token_count (token_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: is a token held, its value, which consumers still owe a transfer.
    bit            m_has;
    logic [DW-1:0] m_data;
    int            m_owed[$];
    int            m_cnt;

    // Values sampled mid-cycle, for directed checks after the cycle completes.
    logic [NO-1:0] s_valid;
    logic [DW-1:0] s_data;
    logic          s_stop;
    logic [15:0]   s_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NO-1:0] model_valid();
        logic [NO-1:0] v = '0;
        if (m_has) foreach (m_owed[k]) v[m_owed[k]] = 1'b1;
        return v;
    endfunction

    function automatic bit model_stalled();
        bit st = 0;
        if (m_has) foreach (m_owed[k]) if (stop_output[m_owed[k]]) st = 1;
        return st;
    endfunction

    // Drive one cycle of inputs, compare outputs against the model, then advance the model.
    task automatic cycle(input logic rst, input logic vin, input logic [DW-1:0] din,
                         input logic [NO-1:0] mask, input logic [NO-1:0] stop);
        bit stall, xfer;
        int keep[$];
        reset       = rst;
        valid_input = vin;
        input_data  = din;
        output_mask = mask;
        stop_output = stop;
        #1;
        s_valid = valid_output;
        s_data  = output_data;
        s_stop  = stop_input;
        s_cnt   = token_count;
        stall   = model_stalled();
        check_eq("valid_output", 64'(valid_output), 64'(model_valid()));
        check_eq("stop_input", 64'(stop_input), 64'(stall));
        check_eq("token_count", 64'(token_count), 64'(m_cnt));
        if (m_has) check_eq("output_data", 64'(output_data), 64'(m_data));
        @(posedge clk);
        if (rst) begin
            m_has = 0;
            m_data = '0;
            m_owed.delete();
            m_cnt = 0;
        end else begin
            xfer = vin && !stall;
            if (m_has) begin
                foreach (m_owed[k]) if (stop[m_owed[k]]) keep.push_back(m_owed[k]);
                m_owed = keep;
                if (m_owed.size() == 0) begin
                    m_has = 0;
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end
            if (xfer) begin
                if (mask == '0) begin
                    m_cnt = (m_cnt + 1) % 65536;
                end else begin
                    m_has  = 1;
                    m_data = din;
                    m_owed.delete();
                    for (int p = 0; p < NO; p++) if (mask[p]) m_owed.push_back(p);
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [NO-1:0] exp_v[4];
        m_has = 0;
        m_data = '0;
        m_cnt = 0;
        cycle(1, 1, 32'hdead, 4'hf, 4'h0);
        cycle(1, 0, 0, 4'h0, 4'h0);
        // Post-reset idle outputs.
        cycle(0, 0, 0, 4'hf, 4'h0);
        check_eq("rst_valid", 64'(s_valid), 64'h0);
        check_eq("rst_stop", 64'(s_stop), 64'h0);
        check_eq("rst_data", 64'(s_data), 64'h0);
        check_eq("rst_cnt", 64'(s_cnt), 64'h0);

        // Single token to all four consumers.
        cycle(0, 1, 32'h5, 4'hf, 4'h0);
        cycle(0, 0, 0, 4'hf, 4'h0);
        check_eq("s31_valid", 64'(s_valid), 64'hf);
        check_eq("s31_data", 64'(s_data), 64'h5);
        cycle(0, 0, 0, 4'hf, 4'h0);
        check_eq("s31_empty", 64'(s_valid), 64'h0);
        check_eq("s31_cnt", 64'(s_cnt), 64'h1);

        // Port 1 stalls three cycles.
        exp_v = '{4'hf, 4'h2, 4'h2, 4'h2};
        cycle(0, 1, 32'h9, 4'hf, 4'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 4'hf, (k < 3) ? 4'h2 : 4'h0);
            check_eq("s32_valid", 64'(s_valid), 64'(exp_v[k]));
            check_eq("s32_stop", 64'(s_stop), (k < 3) ? 64'h1 : 64'h0);
        end
        cycle(0, 0, 0, 4'hf, 4'h0);
        check_eq("s32_cnt", 64'(s_cnt), 64'h2);

        // Back-to-back tokens at full rate.
        for (int k = 1; k <= 4; k++) begin
            cycle(0, (k <= 3), 32'(k), 4'hf, 4'h0);
            check_eq("s33_stop", 64'(s_stop), 64'h0);
            if (k > 1) check_eq("s33_data", 64'(s_data), 64'(k - 1));
        end
        cycle(0, 0, 0, 4'hf, 4'h0);
        check_eq("s33_cnt", 64'(s_cnt), 64'h5);

        // Empty mask discards the token but counts it.
        cycle(0, 1, 32'h7, 4'h0, 4'h0);
        cycle(0, 0, 0, 4'h0, 4'h0);
        check_eq("s34_valid", 64'(s_valid), 64'h0);
        check_eq("s34_cnt", 64'(s_cnt), 64'h6);

        // Mask changes while FULL are ignored.
        cycle(0, 1, 32'h11, 4'h5, 4'h0);
        cycle(0, 0, 0, 4'hf, 4'h5);
        check_eq("s35_valid_a", 64'(s_valid), 64'h5);
        cycle(0, 0, 0, 4'hf, 4'h1);
        check_eq("s35_valid_b", 64'(s_valid), 64'h5);
        cycle(0, 0, 0, 4'hf, 4'h0);
        check_eq("s35_valid_c", 64'(s_valid), 64'h1);
        cycle(0, 0, 0, 4'hf, 4'h0);
        check_eq("s35_valid_d", 64'(s_valid), 64'h0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom,
                  ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom),
                  ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom));
        end

        // Counter wrap.
        cycle(1, 0, 0, 4'h0, 4'h0);
        for (int k = 0; k < 65535; k++) cycle(0, 1, 32'(k), 4'hf, 4'h0);
        cycle(0, 0, 0, 4'hf, 4'h0);
        cycle(0, 0, 0, 4'hf, 4'h0);
        check_eq("cnt_ffff", 64'(s_cnt), 64'hffff);
        cycle(0, 1, 32'h3, 4'hf, 4'h0);
        cycle(0, 0, 0, 4'hf, 4'h0);
        cycle(0, 0, 0, 4'hf, 4'h0);
        check_eq("cnt_wrap", 64'(s_cnt), 64'h0);

        // Reset while port 1 still pending.
        cycle(0, 1, 32'h44, 4'hf, 4'h2);
        cycle(0, 0, 0, 4'hf, 4'h2);
        check_eq("mid_valid", 64'(s_valid), 64'hf);
        cycle(1, 1, 32'h55, 4'hf, 4'h2);
        check_eq("mid_pend", 64'(s_valid), 64'h2);
        cycle(0, 0, 0, 4'hf, 4'h2);
        check_eq("post_rst_valid", 64'(s_valid), 64'h0);
        check_eq("post_rst_data", 64'(s_data), 64'h0);
        check_eq("post_rst_stop", 64'(s_stop), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
